round_robin_logic: RTL
======================

// Module: round_robin_logic
// PURPOSE
//  Round-robin grant scheduler for the 4-client bus arbiter. It is the alternative to the
//  strict-priority scheduler and is selected when the scheduling algorithm bit is 1.
//  It picks one requesting client at a time and holds the grant for that whole transaction.
//  The chosen client index goes to the arbiter's server/client muxes. A watchdog reclaims a
//  grant when the server never acknowledges.
// PARAMETERS
//  TIMEOUT_CYCLES  16  BUSY cycles without server_ack before the grant is forcibly released (>=2)
//  TIMEOUT_WIDTH   5   Watchdog counter width; must hold TIMEOUT_CYCLES-1
// PORTS
//  clk                   in   1  system clock; all logic is on the rising edge
//  reset                 in   1  asynchronous, active-low reset
//  enable                in   1  1 = scheduler may issue new grants
//  client_1_rq           in   1  request from client 1 (index 2'b00)
//  client_2_rq           in   1  request from client 2 (index 2'b01)
//  client_3_rq           in   1  request from client 3 (index 2'b10)
//  client_4_rq           in   1  request from client 4 (index 2'b11)
//  server_ack            in   1  server completion strobe for the granted transaction
//  address_to_be_served  out  2  index of the granted client (registered)
//  grant_valid           out  1  1 while address_to_be_served owns the bus (registered)
//  timeout_err           out  1  one-cycle pulse when the watchdog releases a grant
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - state=IDLE, address_to_be_served=2'b00, grant_valid=0, timeout_err=0, wdog=0.
//   - last_served=2'b11, so client 1 wins first.
//  Search order: last_served+1, +2, +3, +4, modulo 4 with 2-bit wrap (2'b11+1=2'b00).
//   The first asserted rq in that order wins.
//  FSM states: IDLE, BUSY, RELEASE.
//   IDLE: if enable=1 and any rq=1:
//    - register the winner into address_to_be_served and set grant_valid=1;
//    - clear wdog and go to BUSY.
//    - Latency: rq sampled at edge N gives the grant visible after edge N+1... i.e. 1 clk.
//    Otherwise stay in IDLE, grant_valid=0, and address_to_be_served keeps its last value.
//   BUSY: evaluated in priority order each cycle:
//    1) server_ack=1: completion. Go to RELEASE, grant_valid=0, last_served=granted index.
//    2) granted rq=0 (abandon): go to IDLE, grant_valid=0, last_served=granted index.
//    3) wdog==TIMEOUT_CYCLES-1: timeout_err=1 for one cycle. Go to RELEASE, grant_valid=0,
//       last_served=granted index.
//    4) otherwise: wdog+1 and stay in BUSY.
//   RELEASE: wait until the granted client's rq=0, then go to IDLE. This prevents
//    re-arbitrating on a stale rq. The new grant can issue earliest 1 clk after rq drops.
//  Simultaneous events:
//   - ack together with rq drop counts as completion (rule 1).
//   - ack on the timeout cycle counts as completion, with no timeout_err.
//  enable=0 blocks only IDLE->BUSY. A transaction already in BUSY or RELEASE runs to its end.
//  The grant never changes while grant_valid=1. Clients that are not granted and drop rq
//   cause no effect.
//  Reset asserted mid-transaction aborts it immediately to the reset values. No timeout_err.
// TESTING
//  T1 reset: reset=0 with rqs random -> addr=2'b00, grant_valid=0, timeout_err=0. Release
//   reset with rq1=1 -> addr=00 and grant_valid=1 after 1 clk.
//  T2 rotation: all 4 rq held high; each grant is acked after 3 cycles and rq is pulsed low for
//   1 cycle after each ack -> grant order 00,01,10,11,00.
//  T3 fairness skip: last_served=01, rq3=0, rq1=rq4=1 -> next grant 11, then 00.
//  T4 timeout: TIMEOUT_CYCLES=16, client 2 granted, no ack -> timeout_err pulses in the 16th
//   BUSY cycle and grant_valid=0. Ack on that exact cycle -> no pulse.
//  T5 abandon/enable: client 3 drops rq in BUSY -> IDLE next clk with last_served=10.
//   enable=0 with rq4=1 -> no grant; enable=1 -> grant 11 after 1 clk.
//  T6 reset mid-BUSY: reset=0 while client 4 is granted -> outputs go to reset values
//   asynchronously, before the next clk edge.

Source files
------------

// File: rtl/round_robin_logic.sv
// Round-robin grant scheduler for the 4-client bus arbiter.
// Holds one grant per transaction; watchdog reclaims unacknowledged grants.
module round_robin_logic #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TIMEOUT_WIDTH  = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       client_1_rq,
   input  logic       client_2_rq,
   input  logic       client_3_rq,
   input  logic       client_4_rq,
   input  logic       server_ack,
   output logic [1:0] address_to_be_served,
   output logic       grant_valid,
   output logic       timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_RELEASE
   } state_t;

   localparam logic [TIMEOUT_WIDTH-1:0] WDOG_MAX =
      TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t                   r_state;
   logic [1:0]               r_addr;
   logic                     r_grant_valid;
   logic                     r_timeout_err;
   logic [TIMEOUT_WIDTH-1:0] r_wdog;
   logic [1:0]               r_last;

   logic [3:0] w_rq;
   logic [1:0] w_c1;
   logic [1:0] w_c2;
   logic [1:0] w_c3;
   logic [1:0] w_c4;
   logic [1:0] w_win;
   logic       w_any;
   logic       w_granted_rq;

   assign w_rq = {client_4_rq, client_3_rq,
                  client_2_rq, client_1_rq};
   assign w_any = |w_rq;
   assign w_granted_rq = w_rq[r_addr];

   assign w_c1 = r_last + 2'd1;
   assign w_c2 = r_last + 2'd2;
   assign w_c3 = r_last + 2'd3;
   assign w_c4 = r_last;

   // First requester after the last served client wins
   always_comb begin
      w_win = w_c4;
      if (w_rq[w_c1])      w_win = w_c1;
      else if (w_rq[w_c2]) w_win = w_c2;
      else if (w_rq[w_c3]) w_win = w_c3;
      else                 w_win = w_c4;
   end

   // Grant FSM with registered outputs and watchdog
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_addr        <= 2'b00;
         r_grant_valid <= 1'b0;
         r_timeout_err <= 1'b0;
         r_wdog        <= '0;
         r_last        <= 2'b11;
      end else begin
         r_timeout_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (enable && w_any) begin
                  r_addr        <= w_win;
                  r_grant_valid <= 1'b1;
                  r_wdog        <= '0;
                  r_state       <= S_BUSY;
               end else begin
                  r_grant_valid <= 1'b0;
               end
            end
            S_BUSY: begin
               if (server_ack) begin
                  r_grant_valid <= 1'b0;
                  r_last        <= r_addr;
                  r_state       <= S_RELEASE;
               end else if (!w_granted_rq) begin
                  r_grant_valid <= 1'b0;
                  r_last        <= r_addr;
                  r_state       <= S_IDLE;
               end else if (r_wdog == WDOG_MAX) begin
                  r_timeout_err <= 1'b1;
                  r_grant_valid <= 1'b0;
                  r_last        <= r_addr;
                  r_state       <= S_RELEASE;
               end else begin
                  r_wdog <= r_wdog + TIMEOUT_WIDTH'(1);
               end
            end
            S_RELEASE: begin
               if (!w_granted_rq) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_grant_valid <= 1'b0;
               r_state       <= S_IDLE;
            end
         endcase
      end
   end

   assign address_to_be_served = r_addr;
   assign grant_valid          = r_grant_valid;
   assign timeout_err          = r_timeout_err;

endmodule
